port_agent: RTL and testbench

Device-side agent on the far end of the CPU's 16-bit I/O ports. It captures every word the CPU writes with OUT into a transmit FIFO, which an external consumer drains over valid/ready. It also accepts words from an external producer over valid/ready and presents them one at a time on the CPU's `in_port`, advancing when the CPU consumes one with IN. It sits at the top level beside `cpu`, wired to `out_port`/`in_port` plus the two CPU strobes.

---
 rtl/port_agent_if.sv | 33 +++
 rtl/port_agent.sv | 205 ++++++++++++++++++++
 tb/tb_port_agent.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/port_agent_if.sv
// port_agent_if: bundles the CPU port, TX drain and RX fill handshakes plus the
// sticky error flags seen by port_agent.
// The slave modport is the agent's view; the master modport is the view of
// everything wired around it (CPU strobes, consumer, producer).

interface port_agent_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] cpu_out_data;
   logic             cpu_out_stb;
   logic [WIDTH-1:0] cpu_in_data;
   logic             cpu_in_ack;
   logic             cpu_in_avail;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic             ovf;
   logic             udf;
   logic             flag_clr;

   modport slave (
      input  cpu_out_data, cpu_out_stb, cpu_in_ack, tx_ready, rx_data, rx_valid, flag_clr,
      output cpu_in_data, cpu_in_avail, tx_data, tx_valid, rx_ready, ovf, udf
   );

   modport master (
      output cpu_out_data, cpu_out_stb, cpu_in_ack, tx_ready, rx_data, rx_valid, flag_clr,
      input  cpu_in_data, cpu_in_avail, tx_data, tx_valid, rx_ready, ovf, udf
   );
endinterface

// File: rtl/port_agent.sv
// port_agent: device-side agent for the CPU's 16-bit I/O ports.
// CPU OUT words land in a show-ahead TX FIFO drained over valid/ready; words from
// an external producer are staged through a two-deep RX path (cur + skid nxt)
// and presented on cpu_in_data until the CPU acknowledges them with IN.
// Optional feature: define PORT_AGENT_LOOPBACK_EN to add the lb_en input, which
// routes the TX FIFO head into the RX path instead of the external handshakes.

module port_agent #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic clk,
   input  logic rst,
`ifdef PORT_AGENT_LOOPBACK_EN
   input  logic lb_en,
`endif
   port_agent_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } rxState_t;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;

   rxState_t         r_state;
   rxState_t         w_stateNext;
   logic [WIDTH-1:0] r_cur;
   logic [WIDTH-1:0] r_nxt;
   logic             r_ovf;
   logic             r_udf;

   logic             w_lb;
   logic             w_headValid;
   logic [WIDTH-1:0] w_head;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_ovfSet;
   logic             w_rxRoom;
   logic             w_rxSrcValid;
   logic [WIDTH-1:0] w_rxSrcData;
   logic             w_rxAccept;
   logic             w_curLoadRx;
   logic             w_curLoadNxt;
   logic             w_nxtLoad;
   logic             w_udfSet;

`ifdef PORT_AGENT_LOOPBACK_EN
   logic r_lbEn;

   // Register the loopback select so a toggle only takes effect on the next cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lbEn <= 1'b0;
      end else begin
         r_lbEn <= lb_en;
      end
   end

   assign w_lb = r_lbEn;
`else
   assign w_lb = 1'b0;
`endif

   assign w_headValid = (r_count != '0);
   assign w_head      = r_mem[r_rdPtr];
   assign w_full      = (r_count == (AW + 1)'(DEPTH));
   assign w_rxRoom    = (r_state != S_TWO);

   // In loopback the FIFO head replaces the external producer
   assign w_rxSrcValid = w_lb ? w_headValid : bus.rx_valid;
   assign w_rxSrcData  = w_lb ? w_head      : bus.rx_data;
   assign w_rxAccept   = w_rxSrcValid && w_rxRoom && rst;

   // A pop is either the external consumer taking the head or, in loopback, the RX path accepting it
   assign w_pop    = w_headValid && (w_lb ? (w_rxRoom && rst) : bus.tx_ready);
   assign w_push   = bus.cpu_out_stb && (!w_full || w_pop);
   assign w_ovfSet = bus.cpu_out_stb && w_full && !w_pop;

   // TX FIFO storage, pointers and occupancy count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= bus.cpu_out_data;
            r_wrPtr        <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // RX state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // RX next state and data-load controls; an ack with nothing held flags underflow
   always_comb begin
      w_stateNext  = r_state;
      w_curLoadRx  = 1'b0;
      w_curLoadNxt = 1'b0;
      w_nxtLoad    = 1'b0;
      w_udfSet     = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (bus.cpu_in_ack) begin
               w_udfSet = 1'b1;
            end
            if (w_rxAccept) begin
               w_curLoadRx = 1'b1;
               w_stateNext = S_ONE;
            end
         end
         S_ONE: begin
            if (w_rxAccept && bus.cpu_in_ack) begin
               w_curLoadRx = 1'b1;
            end else if (w_rxAccept) begin
               w_nxtLoad   = 1'b1;
               w_stateNext = S_TWO;
            end else if (bus.cpu_in_ack) begin
               w_stateNext = S_EMPTY;
            end
         end
         S_TWO: begin
            if (bus.cpu_in_ack) begin
               w_curLoadNxt = 1'b1;
               w_stateNext  = S_ONE;
            end
         end
         default: begin
            w_stateNext = S_EMPTY;
         end
      endcase
   end

   // RX data registers: cur is what the CPU sees, nxt is the skid slot
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cur <= '0;
         r_nxt <= '0;
      end else begin
         if (w_curLoadRx) begin
            r_cur <= w_rxSrcData;
         end else if (w_curLoadNxt) begin
            r_cur <= r_nxt;
         end
         if (w_nxtLoad) begin
            r_nxt <= w_rxSrcData;
         end
      end
   end

   // Sticky error flags; a new event wins over a clear in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         if (w_ovfSet) begin
            r_ovf <= 1'b1;
         end else if (bus.flag_clr) begin
            r_ovf <= 1'b0;
         end
         if (w_udfSet) begin
            r_udf <= 1'b1;
         end else if (bus.flag_clr) begin
            r_udf <= 1'b0;
         end
      end
   end

   assign bus.tx_data      = w_head;
   assign bus.tx_valid     = w_headValid && !w_lb;
   assign bus.rx_ready     = w_rxRoom && rst && !w_lb;
   assign bus.cpu_in_data  = r_cur;
   assign bus.cpu_in_avail = (r_state != S_EMPTY);
   assign bus.ovf          = r_ovf;
   assign bus.udf          = r_udf;

endmodule

// File: tb/tb_port_agent.sv
// tb_port_agent: directed vector table plus hand-written reset and loopback
// sequences for port_agent.

module tb_port_agent;

   logic clk;
   logic rst;
`ifdef PORT_AGENT_LOOPBACK_EN
   logic lb_en;
`endif

   int total;
   int bad;

   port_agent_if #(.WIDTH(16)) bus ();

   port_agent #(.DEPTH(8), .WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef PORT_AGENT_LOOPBACK_EN
      .lb_en (lb_en),
`endif
      .bus   (bus)
   );

   typedef struct {
      logic        stb;
      logic [15:0] outData;
      logic        txReady;
      logic        rxValid;
      logic [15:0] rxData;
      logic        ack;
      logic        clr;
      logic        expTxValid;
      logic        chkTxData;
      logic [15:0] expTxData;
      logic        expAvail;
      logic [15:0] expInData;
      logic        expRxReady;
      logic        expOvf;
      logic        expUdf;
   } vec_t;

   vec_t vecs[$];

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic stb, input logic [15:0] od, input logic txr,
      input logic rxv, input logic [15:0] rxd, input logic ack, input logic clr,
      input logic etv, input logic ctd, input logic [15:0] etd,
      input logic eav, input logic [15:0] eid, input logic err,
      input logic eovf, input logic eudf);
      vec_t v;
      v.stb = stb; v.outData = od; v.txReady = txr;
      v.rxValid = rxv; v.rxData = rxd; v.ack = ack; v.clr = clr;
      v.expTxValid = etv; v.chkTxData = ctd; v.expTxData = etd;
      v.expAvail = eav; v.expInData = eid; v.expRxReady = err;
      v.expOvf = eovf; v.expUdf = eudf;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic driveIdle();
      bus.cpu_out_stb  = 1'b0;
      bus.cpu_out_data = '0;
      bus.tx_ready     = 1'b0;
      bus.rx_valid     = 1'b0;
      bus.rx_data      = '0;
      bus.cpu_in_ack   = 1'b0;
      bus.flag_clr     = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      bus.cpu_out_stb  = v.stb;
      bus.cpu_out_data = v.outData;
      bus.tx_ready     = v.txReady;
      bus.rx_valid     = v.rxValid;
      bus.rx_data      = v.rxData;
      bus.cpu_in_ack   = v.ack;
      bus.flag_clr     = v.clr;
   endtask

   task automatic checkVector(input int idx, input vec_t v);
      checkOutput($sformatf("v%0d tx_valid", idx), 32'(bus.tx_valid), 32'(v.expTxValid));
      if (v.chkTxData) begin
         checkOutput($sformatf("v%0d tx_data", idx), 32'(bus.tx_data), 32'(v.expTxData));
      end
      checkOutput($sformatf("v%0d in_avail", idx), 32'(bus.cpu_in_avail), 32'(v.expAvail));
      checkOutput($sformatf("v%0d in_data", idx), 32'(bus.cpu_in_data), 32'(v.expInData));
      checkOutput($sformatf("v%0d rx_ready", idx), 32'(bus.rx_ready), 32'(v.expRxReady));
      checkOutput($sformatf("v%0d ovf", idx), 32'(bus.ovf), 32'(v.expOvf));
      checkOutput($sformatf("v%0d udf", idx), 32'(bus.udf), 32'(v.expUdf));
   endtask

   // Main test sequence
   initial begin
      logic [15:0] w;
      total = 0;
      bad   = 0;
      rst   = 1'b0;
`ifdef PORT_AGENT_LOOPBACK_EN
      lb_en = 1'b0;
`endif
      driveIdle();

      // TX fill to full, overflow, clear, then push+pop while full
      for (int k = 1; k <= 8; k++) begin
         w = 16'(32'h1111 * k);
         vecs.push_back(mk(1, w, 0, 0, 0, 0, 0, 1, 1, 16'h1111, 0, 0, 1, 0, 0));
      end
      vecs.push_back(mk(1, 16'hDEAD, 0, 0, 0, 0, 0, 1, 1, 16'h1111, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0,        0, 0, 0, 0, 1, 1, 1, 16'h1111, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 16'hBEEF, 1, 0, 0, 0, 0, 1, 1, 16'h2222, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 16'hCAFE, 0, 0, 0, 0, 0, 1, 1, 16'h2222, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0,        0, 0, 0, 0, 1, 1, 1, 16'h2222, 0, 0, 1, 0, 0));
      // Drain: heads after each pop are 3333..8888, BEEF, then empty
      for (int j = 1; j <= 6; j++) begin
         w = 16'(32'h1111 * (j + 2));
         vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, w, 0, 0, 1, 0, 0));
      end
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 16'hBEEF, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0));
      // RX fill to TWO, blocked accept, acks down to EMPTY, underflow, clear
      vecs.push_back(mk(0, 0, 0, 1, 16'h00A1, 0, 0, 0, 0, 0, 1, 16'h00A1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h00A2, 0, 0, 0, 0, 0, 1, 16'h00A1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h00A3, 0, 0, 0, 0, 0, 1, 16'h00A1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 1, 16'h00A2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00A2, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h00A2, 1, 0, 0));
      // RX streaming: accept and ack every cycle in ONE
      vecs.push_back(mk(0, 0, 0, 1, 16'h00B1, 0, 0, 0, 0, 0, 1, 16'h00B1, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h00B2, 1, 0, 0, 0, 0, 1, 16'h00B2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h00B3, 1, 0, 0, 0, 0, 1, 16'h00B3, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h00B4, 1, 0, 0, 0, 0, 1, 16'h00B4, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 16'h00B5, 1, 0, 0, 0, 0, 1, 16'h00B5, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h00B5, 1, 0, 0));
      // Set beats clear, then clear alone
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 1, 0, 0, 0, 0, 16'h00B5, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h00B5, 1, 0, 0));
      // Push+pop on empty FIFO is push only; then steady push+pop at count 1
      vecs.push_back(mk(1, 16'h1234, 1, 0, 0, 0, 0, 1, 1, 16'h1234, 0, 16'h00B5, 1, 0, 0));
      vecs.push_back(mk(1, 16'h5678, 1, 0, 0, 0, 0, 1, 1, 16'h5678, 0, 16'h00B5, 1, 0, 0));
      vecs.push_back(mk(0, 0,        1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h00B5, 1, 0, 0));

      // Reset held with random inputs: every output stays 0
      for (int c = 0; c < 4; c++) begin
         bus.cpu_out_stb  = 1'($urandom);
         bus.cpu_out_data = 16'($urandom);
         bus.tx_ready     = 1'($urandom);
         bus.rx_valid     = 1'($urandom);
         bus.rx_data      = 16'($urandom);
         bus.cpu_in_ack   = 1'($urandom);
         bus.flag_clr     = 1'($urandom);
         @(posedge clk);
         #1;
         checkOutput("rst tx_valid", 32'(bus.tx_valid), 0);
         checkOutput("rst tx_data", 32'(bus.tx_data), 0);
         checkOutput("rst rx_ready", 32'(bus.rx_ready), 0);
         checkOutput("rst in_data", 32'(bus.cpu_in_data), 0);
         checkOutput("rst in_avail", 32'(bus.cpu_in_avail), 0);
         checkOutput("rst ovf", 32'(bus.ovf), 0);
         checkOutput("rst udf", 32'(bus.udf), 0);
      end
      driveIdle();
      rst = 1'b1;
      #1;
      checkOutput("release rx_ready", 32'(bus.rx_ready), 1);
      checkOutput("release tx_valid", 32'(bus.tx_valid), 0);

      // Vector table
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkVector(i, vecs[i]);
      end
      driveIdle();

      // Reset mid-transfer: FIFO holds two words and RX is in TWO, then async reset
      bus.cpu_out_stb = 1'b1; bus.cpu_out_data = 16'hAAAA;
      bus.rx_valid = 1'b1;    bus.rx_data = 16'h00C1;
      @(posedge clk); #1;
      bus.cpu_out_data = 16'hBBBB; bus.rx_data = 16'h00C2;
      @(posedge clk); #1;
      driveIdle();
      checkOutput("pre tx_valid", 32'(bus.tx_valid), 1);
      checkOutput("pre tx_data", 32'(bus.tx_data), 32'h0000AAAA);
      checkOutput("pre rx_ready", 32'(bus.rx_ready), 0);
      checkOutput("pre in_data", 32'(bus.cpu_in_data), 32'h000000C1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("mid tx_valid", 32'(bus.tx_valid), 0);
      checkOutput("mid rx_ready", 32'(bus.rx_ready), 0);
      checkOutput("mid in_data", 32'(bus.cpu_in_data), 0);
      checkOutput("mid in_avail", 32'(bus.cpu_in_avail), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("post tx_valid", 32'(bus.tx_valid), 0);
      checkOutput("post rx_ready", 32'(bus.rx_ready), 1);
      checkOutput("post in_avail", 32'(bus.cpu_in_avail), 0);
      checkOutput("post in_data", 32'(bus.cpu_in_data), 0);

`ifdef PORT_AGENT_LOOPBACK_EN
      // Loopback: CPU OUT word reappears on cpu_in_data two cycles later
      lb_en = 1'b1;
      @(posedge clk); #1;
      checkOutput("lb rx_ready", 32'(bus.rx_ready), 0);
      checkOutput("lb tx_valid0", 32'(bus.tx_valid), 0);
      bus.cpu_out_stb = 1'b1; bus.cpu_out_data = 16'h5A5A;
      @(posedge clk); #1;
      driveIdle();
      checkOutput("lb tx_valid1", 32'(bus.tx_valid), 0);
      checkOutput("lb avail1", 32'(bus.cpu_in_avail), 0);
      @(posedge clk); #1;
      checkOutput("lb tx_valid2", 32'(bus.tx_valid), 0);
      checkOutput("lb in_data", 32'(bus.cpu_in_data), 32'h00005A5A);
      checkOutput("lb avail2", 32'(bus.cpu_in_avail), 1);
      bus.cpu_in_ack = 1'b1;
      @(posedge clk); #1;
      bus.cpu_in_ack = 1'b0;
      checkOutput("lb avail3", 32'(bus.cpu_in_avail), 0);
      lb_en = 1'b0;
      @(posedge clk); #1;
      checkOutput("lb off tx_valid", 32'(bus.tx_valid), 0);
      checkOutput("lb off rx_ready", 32'(bus.rx_ready), 1);
      checkOutput("lb off udf", 32'(bus.udf), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
